// File: rtl/key_switch_input_port.sv
// key_switch_input_port
//
// CPU-readable input peripheral for the board push-buttons and slide
// switches. The raw pins go through a two-flop synchroniser and a per-input
// debouncer. Key presses are latched in a sticky edge-capture register, which
// drives a maskable, level-sensitive interrupt. Everything is read through a
// single-cycle register port.
//
// Ports:
//   iCLOCK    system clock, rising edge
//   iRESET_N  synchronous active-low reset
//   iKEY      raw push-buttons, 0 = pressed
//   iSW       raw slide switches, 1 = on
//   iADDR     register select: 0 switches, 1 keys, 2 edge capture, 3 irq mask
//   iRD       read strobe (one cycle per access)
//   iWR       write strobe (one cycle per access)
//   iDATA     write data
//   oDATA     registered read data, holds between reads
//   oVALID    one-cycle pulse marking oDATA as fresh
//   oIRQ      registered OR of (edge capture & mask)
module key_switch_input_port #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                iCLOCK,
    input  logic                iRESET_N,
    input  logic [NUM_KEYS-1:0] iKEY,
    input  logic [NUM_SW-1:0]   iSW,
    input  logic [1:0]          iADDR,
    input  logic                iRD,
    input  logic                iWR,
    input  logic [31:0]         iDATA,
    output logic [31:0]         oDATA,
    output logic                oVALID,
    output logic                oIRQ
);

    localparam int NUM_IN = NUM_KEYS + NUM_SW;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    // The count that, once incremented, reaches DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_meta_reg, key_sync_reg;
    logic [NUM_SW-1:0]   sw_meta_reg, sw_sync_reg;

    // Keys and switches share one debounce array. Keys are inverted first so
    // that every bit is 1 = active, and 0 is the reset level for all of them.
    logic [NUM_IN-1:0]   sample;
    logic [NUM_IN-1:0]   level_reg, level_next;

    logic [NUM_KEYS-1:0] key_level, press;
    logic [NUM_SW-1:0]   sw_level;

    logic [NUM_KEYS-1:0] capture_reg, capture_next;
    logic [NUM_KEYS-1:0] mask_reg, mask_next;
    logic [31:0]         data_reg, rd_data;
    logic                valid_reg, irq_reg;

    logic                unused_data;
    assign unused_data = ^iDATA[31:NUM_KEYS];

    always_ff @(posedge iCLOCK) begin
        if (!iRESET_N) begin
            key_meta_reg <= '1;
            key_sync_reg <= '1;
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
        end else begin
            key_meta_reg <= iKEY;
            key_sync_reg <= key_meta_reg;
            sw_meta_reg  <= iSW;
            sw_sync_reg  <= sw_meta_reg;
        end
    end

    assign sample = {sw_sync_reg, ~key_sync_reg};

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             lvl_next;

            // Any sample that agrees with the current level restarts the
            // count, so only an unbroken run of DEBOUNCE_CYCLES disagreeing
            // samples flips the level.
            always_comb begin
                cnt_next = '0;
                lvl_next = level_reg[gi];
                if (sample[gi] != level_reg[gi]) begin
                    if (cnt_reg == CNT_LAST) begin
                        lvl_next = sample[gi];
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge iCLOCK) begin
                if (!iRESET_N) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign level_next[gi] = lvl_next;
        end
    endgenerate

    assign key_level = level_reg[NUM_KEYS-1:0];
    assign sw_level  = level_reg[NUM_IN-1:NUM_KEYS];

    // Press is detected on the edge where the key level rises, so the capture
    // bit and the level become visible together.
    assign press = level_next[NUM_KEYS-1:0] & ~key_level;

    always_comb begin
        rd_data = '0;
        case (iADDR)
            2'd0:    rd_data[NUM_SW-1:0]   = sw_level;
            2'd1:    rd_data[NUM_KEYS-1:0] = key_level;
            2'd2:    rd_data[NUM_KEYS-1:0] = capture_reg;
            default: rd_data[NUM_KEYS-1:0] = mask_reg;
        endcase
    end

    always_comb begin
        capture_next = capture_reg;
        mask_next    = mask_reg;
        if (iRD && iADDR == 2'd2) begin
            capture_next = '0;
        end
        if (iWR && iADDR == 2'd2) begin
            capture_next = capture_next & ~iDATA[NUM_KEYS-1:0];
        end
        if (iWR && iADDR == 2'd3) begin
            mask_next = iDATA[NUM_KEYS-1:0];
        end
        // A press arriving with a clear must not be lost.
        capture_next = capture_next | press;
    end

    always_ff @(posedge iCLOCK) begin
        if (!iRESET_N) begin
            level_reg   <= '0;
            capture_reg <= '0;
            mask_reg    <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            level_reg   <= level_next;
            capture_reg <= capture_next;
            mask_reg    <= mask_next;
            valid_reg   <= iRD;
            if (iRD) begin
                data_reg <= rd_data;
            end
            irq_reg     <= |(capture_reg & mask_reg);
        end
    end

    assign oDATA  = data_reg;
    assign oVALID = valid_reg;
    assign oIRQ   = irq_reg;

endmodule

// File: tb/tb_key_switch_input_port.sv
// Testbench for key_switch_input_port with DEBOUNCE_CYCLES = 4.
// Reads push their expected data into a scoreboard queue; a monitor pops and
// compares on every oVALID. Interrupt and reset values are checked inline.
module tb_key_switch_input_port;

    localparam int NK = 4;
    localparam int NS = 18;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key;
    logic [NS-1:0] sw;
    logic [1:0]    addr;
    logic          rd, wr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          valid, irq;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    key_switch_input_port #(
        .NUM_KEYS(NK),
        .NUM_SW(NS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .iCLOCK(clk),
        .iRESET_N(rst_n),
        .iKEY(key),
        .iSW(sw),
        .iADDR(addr),
        .iRD(rd),
        .iWR(wr),
        .iDATA(wdata),
        .oDATA(rdata),
        .oVALID(valid),
        .oIRQ(irq)
    );

    always #5 clk = ~clk;

    // Monitor: every read response must match the oldest expectation.
    always @(negedge clk) begin
        if (valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: oDATA=%08h with no read pending", rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rdata !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: oDATA=%08h expected %08h", e.name, rdata, e.exp);
                end else begin
                    $display("read %s: oDATA=%08h", e.name, rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_op(input logic [1:0] a, input logic [31:0] e, input string n);
        exp_t x;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
        addr = a;
        rd   = 1'b1;
        cyc(1);
        rd   = 1'b0;
    endtask

    task automatic wr_op(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        cyc(1);
        wr    = 1'b0;
        $display("write addr=%0d data=%08h", a, d);
    endtask

    task automatic rdwr_op(input logic [1:0] a, input logic [31:0] d,
                           input logic [31:0] e, input string n);
        exp_t x;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
        addr  = a;
        wdata = d;
        rd    = 1'b1;
        wr    = 1'b1;
        cyc(1);
        rd    = 1'b0;
        wr    = 1'b0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", n, act, e);
        end else begin
            $display("check %s: %08h", n, act);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key   = '1;
        sw    = '0;
        addr  = 2'd3;
        rd    = 1'b1;           // reset must swallow these
        wr    = 1'b1;
        wdata = 32'hFFFF_FFFF;
        cyc(3);
        chk("reset_odata", rdata, 32'h0);
        chk("reset_ovalid", {31'b0, valid}, 32'h0);
        chk("reset_oirq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;

        rd_op(2'd0, 32'h0, "reset_sw");
        rd_op(2'd1, 32'h0, "reset_key");
        rd_op(2'd2, 32'h0, "reset_capture");
        rd_op(2'd3, 32'h0, "reset_mask");

        // Debounce latency: level visible at edge 6, first read showing it at 7.
        wr_op(2'd3, 32'h1);
        key[0] = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            rd_op(2'd1, (i == 7) ? 32'h1 : 32'h0, $sformatf("latency_edge%0d", i));
            if (i == 6) chk("irq_not_yet", {31'b0, irq}, 32'h0);
        end
        chk("irq_after_capture", {31'b0, irq}, 32'h1);
        key[0] = 1'b1;
        cyc(8);
        rd_op(2'd2, 32'h1, "capture_key0");
        chk("irq_during_clear", {31'b0, irq}, 32'h1);
        rd_op(2'd2, 32'h0, "capture_cleared");
        chk("irq_dropped", {31'b0, irq}, 32'h0);

        // Three-sample glitch must be filtered out.
        key[1] = 1'b0;
        cyc(3);
        key[1] = 1'b1;
        cyc(8);
        rd_op(2'd1, 32'h0, "glitch_level");
        rd_op(2'd2, 32'h0, "glitch_capture");

        // Write-1-to-clear.
        key = 4'b1001;
        cyc(8);
        key = 4'hF;
        cyc(8);
        chk("irq_masked_keys12", {31'b0, irq}, 32'h0);
        wr_op(2'd2, 32'h2);
        rd_op(2'd2, 32'h4, "w1c_result");
        rd_op(2'd2, 32'h0, "w1c_then_read");

        // Press completing on the same edge as a clearing read.
        key[2] = 1'b0;
        cyc(8);
        key[2] = 1'b1;
        cyc(8);
        key[1] = 1'b0;
        cyc(5);
        rd_op(2'd2, 32'h4, "collision_old");
        rd_op(2'd2, 32'h2, "collision_kept");
        key[1] = 1'b1;
        cyc(8);

        // Switches and ignored writes.
        sw = 18'h2A5A5;
        cyc(5);
        rd_op(2'd0, 32'h0, "sw_before");
        rd_op(2'd0, 32'h0002_A5A5, "sw_after");
        wr_op(2'd0, 32'hFFFF_FFFF);
        rd_op(2'd0, 32'h0002_A5A5, "sw_write_ignored");
        wr_op(2'd1, 32'hFFFF_FFFF);
        rd_op(2'd1, 32'h0, "key_write_ignored");

        // Masked capture, then unmasking raises the interrupt.
        wr_op(2'd3, 32'h0);
        key[2] = 1'b0;
        cyc(8);
        chk("irq_mask0", {31'b0, irq}, 32'h0);
        wr_op(2'd3, 32'h4);
        chk("irq_same_edge_as_mask", {31'b0, irq}, 32'h0);
        cyc(1);
        chk("irq_after_mask", {31'b0, irq}, 32'h1);
        rdwr_op(2'd3, 32'hFFFF_FFFF, 32'h4, "rdwr_pre_write");
        rd_op(2'd3, 32'hF, "mask_width");
        rd_op(2'd2, 32'h4, "capture_key2");
        cyc(1);
        chk("irq_after_read_clear", {31'b0, irq}, 32'h0);
        key[2] = 1'b1;
        cyc(8);

        // Reset after two debounce counts on key3.
        key[3] = 1'b0;
        cyc(4);
        rst_n = 1'b0;
        addr  = 2'd1;
        rd    = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        rd    = 1'b0;
        chk("midreset_odata", rdata, 32'h0);
        chk("midreset_ovalid", {31'b0, valid}, 32'h0);
        chk("midreset_oirq", {31'b0, irq}, 32'h0);
        cyc(5);
        rd_op(2'd1, 32'h0, "restart_before");
        rd_op(2'd1, 32'h8, "restart_after");
        rd_op(2'd3, 32'h0, "midreset_mask");
        rd_op(2'd2, 32'h8, "capture_key3");

        cyc(3);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: no oVALID seen, expected %08h", e.name, e.exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
